// File: rtl/mipi_csi2_pkt_parser.sv
// CSI-2 packet parser: header ECC check, sync-event decode, payload streaming with CRC-16 footer check.
// Latency: every output is registered, 1 clk after the accepting byte edge (or after the we fall).
// Backpressure: none; a byte is consumed whenever we & dvo, and all state holds while dvo is low.
module mipi_csi2_pkt_parser #(
  parameter bit STRIP_SYNC = 1'b1,
  parameter bit CHECK_ECC  = 1'b1
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        we,
  input  logic        dvo,
  input  logic [7:0]  data,
  output logic        hdr_valid,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic        fs,
  output logic        fe,
  output logic        ls,
  output logic        le,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic        pix_last,
  output logic        ecc_err,
  output logic        crc_err,
  output logic        trunc_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DRAIN
  } state_t;

  state_t      state;
  logic        first_q;     // next accepted byte is the first of the burst
  logic [1:0]  hdr_cnt;     // header bytes captured so far
  logic [7:0]  di_q;
  logic [7:0]  wcl_q;
  logic [7:0]  wcm_q;
  logic [15:0] byte_cnt;    // payload bytes still to come
  logic [15:0] crc_q;
  logic [7:0]  crc_lo_q;
  logic        crc_hi_sel;  // 0: expecting footer LSB, 1: expecting footer MSB

  logic        strip_now;
  logic [23:0] hdr_word;
  logic [5:0]  ecc_calc;
  logic        ecc_bad;
  logic [15:0] wc_rx;
  logic [15:0] crc_next;
  logic [15:0] crc_rx;

  // 6-bit Hamming parity over {WC_MSB, WC_LSB, DI}
  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
         ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
         ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  // Reflected CRC-16-CCITT, one byte per call, data LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The leading sync byte is only recognised on the first accepted byte of a burst
  assign strip_now = STRIP_SYNC && ((state == ST_IDLE) || first_q) && (data == 8'hB8);
  assign hdr_word  = {wcm_q, wcl_q, di_q};
  assign ecc_calc  = hdr_ecc(hdr_word);
  assign ecc_bad   = (ecc_calc != data[5:0]);
  assign wc_rx     = {wcm_q, wcl_q};
  assign crc_next  = crc16_byte(crc_q, data);
  assign crc_rx    = {data, crc_lo_q};

  // Packet FSM with registered sync/payload/error outputs
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      first_q    <= 1'b0;
      hdr_cnt    <= 2'd0;
      di_q       <= 8'h00;
      wcl_q      <= 8'h00;
      wcm_q      <= 8'h00;
      byte_cnt   <= 16'h0000;
      crc_q      <= 16'h0000;
      crc_lo_q   <= 8'h00;
      crc_hi_sel <= 1'b0;
      hdr_valid  <= 1'b0;
      vc         <= 2'd0;
      dt         <= 6'd0;
      wc         <= 16'h0000;
      fs         <= 1'b0;
      fe         <= 1'b0;
      ls         <= 1'b0;
      le         <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= 8'h00;
      pix_last   <= 1'b0;
      ecc_err    <= 1'b0;
      crc_err    <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      fs        <= 1'b0;
      fe        <= 1'b0;
      ls        <= 1'b0;
      le        <= 1'b0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      ecc_err   <= 1'b0;
      crc_err   <= 1'b0;
      trunc_err <= 1'b0;

      case (state)
        // Burst start; the very first cycle may already carry a byte
        ST_IDLE: begin
          if (we) begin
            state   <= ST_HDR;
            first_q <= 1'b1;
            hdr_cnt <= 2'd0;
            if (dvo) begin
              first_q <= 1'b0;
              if (!strip_now) begin
                di_q    <= data;
                hdr_cnt <= 2'd1;
              end
            end
          end
        end

        ST_HDR: begin
          if (!we) begin
            trunc_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (dvo) begin
            first_q <= 1'b0;
            if (!strip_now) begin
              case (hdr_cnt)
                2'd0: begin
                  di_q    <= data;
                  hdr_cnt <= 2'd1;
                end
                2'd1: begin
                  wcl_q   <= data;
                  hdr_cnt <= 2'd2;
                end
                2'd2: begin
                  wcm_q   <= data;
                  hdr_cnt <= 2'd3;
                end
                default: begin
                  // ECC byte: ECC[7:6] are reserved and not compared
                  ecc_err <= ecc_bad;
                  if (ecc_bad && CHECK_ECC) begin
                    state <= ST_DRAIN;
                  end else begin
                    hdr_valid <= 1'b1;
                    vc        <= di_q[7:6];
                    dt        <= di_q[5:0];
                    wc        <= wc_rx;
                    if (di_q[5:4] == 2'b00) begin
                      fs    <= (di_q[5:0] == 6'h00);
                      fe    <= (di_q[5:0] == 6'h01);
                      ls    <= (di_q[5:0] == 6'h02);
                      le    <= (di_q[5:0] == 6'h03);
                      state <= ST_DRAIN;
                    end else begin
                      byte_cnt   <= wc_rx;
                      crc_q      <= 16'hFFFF;
                      crc_hi_sel <= 1'b0;
                      state      <= (wc_rx == 16'h0000) ? ST_CRC : ST_PAYLOAD;
                    end
                  end
                end
              endcase
            end
          end
        end

        // Full 16-bit down-counter, so WC = FFFF runs the whole length
        ST_PAYLOAD: begin
          if (!we) begin
            trunc_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (dvo) begin
            pix_valid <= 1'b1;
            pix_data  <= data;
            crc_q     <= crc_next;
            byte_cnt  <= byte_cnt - 16'd1;
            if (byte_cnt == 16'd1) begin
              pix_last   <= 1'b1;
              crc_hi_sel <= 1'b0;
              state      <= ST_CRC;
            end
          end
        end

        // Footer arrives LSB first
        ST_CRC: begin
          if (!we) begin
            trunc_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (dvo) begin
            if (!crc_hi_sel) begin
              crc_lo_q   <= data;
              crc_hi_sel <= 1'b1;
            end else begin
              crc_err <= (crc_rx != crc_q);
              state   <= ST_DRAIN;
            end
          end
        end

        // One packet per burst: everything after it is discarded
        ST_DRAIN: begin
          if (!we) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
